// File: rtl/alu_operand_loader.sv
// Two-step operand loader: captures A, then B plus op, on rising edges of a load button,
// and hands the set downstream with a valid/ready handshake. Define ALU_LOADER_SYNC_EN to
// pass load/clear through two-flop synchronizers.
module alu_operand_loader #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [OPW-1:0]   op_in,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] inA,
  output logic [WIDTH-1:0] inB,
  output logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       state,
  output logic [7:0]       xfer_count
);

  typedef enum logic [1:0] {
    StWaitA = 2'b00,
    StWaitB = 2'b01,
    StValid = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] in_a_q, in_a_d;
  logic [WIDTH-1:0] in_b_q, in_b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       xfer_q, xfer_d;
  logic             load_q;
  logic             load_s, clear_s;
  logic             load_rise;

`ifdef ALU_LOADER_SYNC_EN
  logic [1:0] load_sync_q, clear_sync_q;

  // load syncs reset high so a held button cannot look like a fresh edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sync_q  <= 2'b11;
      clear_sync_q <= 2'b00;
    end else begin
      load_sync_q  <= {load_sync_q[0], load};
      clear_sync_q <= {clear_sync_q[0], clear};
    end
  end

  assign load_s  = load_sync_q[1];
  assign clear_s = clear_sync_q[1];
`else
  assign load_s  = load;
  assign clear_s = clear;
`endif

  assign load_rise = load_s & ~load_q;

  always_comb begin
    state_d = state_q;
    in_a_d  = in_a_q;
    in_b_d  = in_b_q;
    op_d    = op_q;
    xfer_d  = xfer_q;

    // A handshake completing this cycle counts even if clear also fires
    if (state_q == StValid && out_ready) begin
      xfer_d = xfer_q + 8'd1;
    end

    if (clear_s) begin
      state_d = StWaitA;
      in_a_d  = '0;
      in_b_d  = '0;
      op_d    = '0;
    end else begin
      case (state_q)
        StWaitA: begin
          if (load_rise) begin
            in_a_d  = data_in;
            state_d = StWaitB;
          end
        end
        StWaitB: begin
          if (load_rise) begin
            in_b_d  = data_in;
            op_d    = op_in;
            state_d = StValid;
          end
        end
        StValid: begin
          if (out_ready) begin
            state_d = StWaitA;
          end
        end
        default: state_d = StWaitA;
      endcase
    end

    out_valid_d = (state_d == StValid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitA;
      in_a_q      <= '0;
      in_b_q      <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      xfer_q      <= 8'd0;
      load_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      xfer_q      <= xfer_d;
      load_q      <= load_s;
    end
  end

  assign inA        = in_a_q;
  assign inB        = in_b_q;
  assign op         = op_q;
  assign out_valid  = out_valid_q;
  assign state      = state_q;
  assign xfer_count = xfer_q;

endmodule
